lcd_nibble_rx: RTL and testbench
================================

# lcd_nibble_rx

Panel-side responder for the 4-bit HD44780-style bus produced by our LCD controller. It samples rs/rw/e/db from the bus, assembles nibble pairs into bytes, and executes a reduced instruction set against a 32-byte DDRAM with an address counter and busy flag. It drives status or data nibbles back on read cycles. It serves as the bus model in controller benches and as the receiver in FPGA loopback builds.

## Interface
Parameters:
- BUSY_CYCLES, default 40, busy-flag hold time in clk cycles after each accepted byte (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- lcd_rs  in  1  register select, 0 = instruction/status, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_e  in  1  bus enable strobe, asynchronous to clk.
- lcd_db_in  in  4  bus data nibble, high nibble first.
- lcd_db_out  out  4  read-return nibble.
- lcd_db_oe  out  1  high while this block drives lcd_db_out.
- byte_valid  out  1  one-cycle pulse per accepted write byte.
- byte_rs  out  1  rs of the last accepted byte.
- byte_data  out  8  last accepted byte.
- busy  out  1  busy flag.
- ac  out  5  address counter.
- overrun  out  1  sticky; a write byte completed while busy.
- dbg_addr  in  5  DDRAM debug read address.
- dbg_data  out  8  DDRAM[dbg_addr], combinational.

## Operation
- lcd_e, lcd_rs, lcd_rw and lcd_db_in each pass through a 2-flop synchronizer of equal depth. Edges are detected on the synchronized e against a third delayed copy.
- The phase bit is 0 when the high nibble is expected and 1 when the low nibble is expected. It toggles on every synced e falling edge, for both reads and writes.
- Write with phase 0: latch the high nibble.
- Write with phase 1: form byte = {hi, db}.
  - If busy is high, drop the byte and set overrun.
  - Otherwise execute the byte, pulse byte_valid, update byte_rs/byte_data, and load busy_cnt = BUSY_CYCLES.
- Data byte (rs=1): DDRAM[ac] = byte. ac then increments if id=1, or decrements if id=0, modulo 32.
- Instructions (rs=0), decoded by priority:
  - 1xxxxxxx: ac = byte[4:0].
  - 000001xx: id = byte[1].
  - 0000001x: ac = 0.
  - 00000001 (clear): enter CLEAR. The FSM writes 0x20 to addresses 0..31, one per cycle, over 32 cycles. It then sets ac = 0 and id = 1, and loads busy_cnt = BUSY_CYCLES.
  - All other instructions are accepted with no effect except busy.
- busy = (busy_cnt != 0) | in CLEAR.
- State machine: IDLE (normal operation) → CLEAR on the clear instruction → IDLE after address 31 is written. Writes that complete during CLEAR are dropped and set overrun.
- Read (synced rw=1 while synced e is high):
  - lcd_db_oe = 1.
  - rs=0 returns status {busy, 2'b00, ac}.
  - rs=1 returns DDRAM[ac].
  - phase 0 returns bits [7:4]; phase 1 returns bits [3:0].
- After a rs=1 read completes its phase-1 falling edge, ac advances per id. Reads never set busy or overrun.
- Reset: phase=0, ac=0, id=1, busy_cnt=0, FSM=IDLE, all outputs 0 (lcd_db_out, lcd_db_oe, byte_valid, byte_rs, byte_data, busy, overrun). DDRAM is not reset; its contents are undefined until a clear instruction.
- Reset mid-byte discards a latched high nibble. Reset during CLEAR aborts the sweep.

## Timing
- The bus must hold e high ≥4 clk and low ≥4 clk. rs, rw and db must be stable ≥3 clk before the e falling edge. Shorter pulses are unspecified.
- Write latency: byte_valid, busy rise and ac update occur at the 3rd clk rising edge after e is low at the input.
- busy falls exactly BUSY_CYCLES cycles after it rises, or 32+BUSY_CYCLES cycles after it rises for clear.
- Read: lcd_db_oe and lcd_db_out become valid 3 clk after e rises and drop 3 clk after e falls. Status busy is sampled live and updates while e is high.
- busy_cnt decrements by 1 per cycle and saturates at 0.

## Test plan
- BUSY_CYCLES=40. Write instruction 0x80|0x05 (nibbles 0x8, 0x5), then after busy falls, data 0x41 → byte_valid twice, DDRAM[5]=0x41, ac=6.
- Send clear (0x0, 0x1) → busy held 72 cycles, DDRAM[0..31]=0x20, ac=0, id=1.
- Write entry mode 0x04 (id=0), set ac=0, write data 0x55 → DDRAM[0]=0x55, ac=31 (wrap).
- Write data twice back-to-back without waiting for busy → second byte dropped, overrun=1, DDRAM updated once, byte_valid pulses once.
- With ac=0x12 and busy high, issue a status read (rs=0, rw=1) → nibbles 0x9, 0x2. A data read at ac=5 holding 0x41 returns 0x4, 0x1, then ac=6.
- Assert rst after one high nibble of 0xA → all outputs 0. The next nibble pair 0x4, 0x2 is accepted as byte 0x42.

Source files
------------

// File: rtl/lcd_nibble_rx.sv
// lcd_nibble_rx
// Panel-side responder for a 4-bit HD44780-style bus. Bus signals are
// synchronized into clk, nibble pairs are assembled into bytes, and a reduced
// instruction set is executed against a 32-byte DDRAM with an address counter
// and busy flag. Read cycles are answered with status or DDRAM nibbles.
module lcd_nibble_rx #(
    parameter int BUSY_CYCLES = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [3:0] lcd_db_in,
    output logic [3:0] lcd_db_out,
    output logic       lcd_db_oe,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       busy,
    output logic [4:0] ac,
    output logic       overrun,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int               CNT_W      = $clog2(BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [7:0]       BLANK_CHAR = 8'h20;
    localparam logic [4:0]       LAST_ADDR  = 5'd31;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Synchronizer chains; e carries one extra stage for edge detection.
    logic       r_e_s1, r_e_s2, r_e_s3;
    logic       r_rs_s1, r_rs_s2;
    logic       r_rw_s1, r_rw_s2;
    logic [3:0] r_db_s1, r_db_s2;

    // Byte assembly and instruction state.
    logic             r_phase;
    logic [3:0]       r_hi;
    logic [4:0]       r_ac;
    logic             r_id;
    logic [CNT_W-1:0] r_busy_cnt;
    logic [4:0]       r_clr_addr;
    state_t           r_state;
    state_t           w_state_nxt;

    // Registered outputs.
    logic       r_byte_valid;
    logic       r_byte_rs;
    logic [7:0] r_byte_data;
    logic       r_overrun;
    logic [3:0] r_db_out;
    logic       r_db_oe;

    // Display data RAM; not reset, contents undefined until a clear.
    logic [7:0] r_ddram [0:31];

    // Combinational helpers.
    logic       w_e_fall;
    logic       w_wr_hi;
    logic       w_wr_done;
    logic [7:0] w_byte;
    logic       w_busy;
    logic       w_accept;
    logic       w_drop;
    logic       w_is_clear;
    logic       w_rd_adv;
    logic [4:0] w_ac_step;
    logic [7:0] w_rd_byte;
    logic [3:0] w_rd_nib;
    logic [4:0] w_ins_ac_nxt;
    logic       w_ins_id_nxt;
    logic       w_ins_clear;
    logic       w_clr_we;
    logic       w_clr_done;

    assign w_e_fall   = r_e_s3 & ~r_e_s2;
    assign w_wr_hi    = w_e_fall & ~r_rw_s2 & ~r_phase;
    assign w_wr_done  = w_e_fall & ~r_rw_s2 &  r_phase;
    assign w_byte     = {r_hi, r_db_s2};
    assign w_busy     = (r_busy_cnt != '0) | (r_state == ST_CLEAR);
    // A completed write is executed only when idle and not busy; otherwise it is lost.
    assign w_accept   = w_wr_done & ~w_busy;
    assign w_drop     = w_wr_done &  w_busy;
    assign w_is_clear = w_accept & ~r_rs_s2 & w_ins_clear;
    // Data reads step the address counter once the low nibble has been taken.
    assign w_rd_adv   = w_e_fall & r_rw_s2 & r_phase & r_rs_s2;
    assign w_ac_step  = r_id ? (r_ac + 5'd1) : (r_ac - 5'd1);
    // Status is sampled live so a host polling busy sees it fall mid-strobe.
    assign w_rd_byte  = r_rs_s2 ? r_ddram[r_ac] : {w_busy, 2'b00, r_ac};
    assign w_rd_nib   = r_phase ? w_rd_byte[3:0] : w_rd_byte[7:4];

    assign lcd_db_out = r_db_out;
    assign lcd_db_oe  = r_db_oe;
    assign byte_valid = r_byte_valid;
    assign byte_rs    = r_byte_rs;
    assign byte_data  = r_byte_data;
    assign busy       = w_busy;
    assign ac         = r_ac;
    assign overrun    = r_overrun;
    assign dbg_data   = r_ddram[dbg_addr];

    // Bring the asynchronous bus into the clk domain, all with equal depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_s1  <= 1'b0;
            r_e_s2  <= 1'b0;
            r_e_s3  <= 1'b0;
            r_rs_s1 <= 1'b0;
            r_rs_s2 <= 1'b0;
            r_rw_s1 <= 1'b0;
            r_rw_s2 <= 1'b0;
            r_db_s1 <= 4'h0;
            r_db_s2 <= 4'h0;
        end else begin
            r_e_s1  <= lcd_e;
            r_e_s2  <= r_e_s1;
            r_e_s3  <= r_e_s2;
            r_rs_s1 <= lcd_rs;
            r_rs_s2 <= r_rs_s1;
            r_rw_s1 <= lcd_rw;
            r_rw_s2 <= r_rw_s1;
            r_db_s1 <= lcd_db_in;
            r_db_s2 <= r_db_s1;
        end
    end

    // Instruction decode by priority: set-address, entry mode, home, clear.
    always_comb begin
        w_ins_ac_nxt = r_ac;
        w_ins_id_nxt = r_id;
        w_ins_clear  = 1'b0;
        if (w_byte[7]) begin
            w_ins_ac_nxt = w_byte[4:0];
        end else if (w_byte[7:2] == 6'b000001) begin
            w_ins_id_nxt = w_byte[1];
        end else if (w_byte[7:1] == 7'b0000001) begin
            w_ins_ac_nxt = 5'd0;
        end else if (w_byte == 8'h01) begin
            w_ins_clear = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: the clear sweep fills one address per cycle until 31.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        w_clr_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_clear) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_clr_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Nibble phase tracks every strobe; the high nibble is held for pairing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_hi    <= 4'h0;
        end else begin
            if (w_e_fall) begin
                r_phase <= ~r_phase;
            end
            if (w_wr_hi) begin
                r_hi <= r_db_s2;
            end
        end
    end

    // Address counter and entry direction; end of clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ac <= 5'd0;
            r_id <= 1'b1;
        end else if (w_clr_done) begin
            r_ac <= 5'd0;
            r_id <= 1'b1;
        end else if (w_accept) begin
            if (r_rs_s2) begin
                r_ac <= w_ac_step;
            end else begin
                r_ac <= w_ins_ac_nxt;
                r_id <= w_ins_id_nxt;
            end
        end else if (w_rd_adv) begin
            r_ac <= w_ac_step;
        end
    end

    // Busy counter reloads on each accepted byte and again when a clear ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_accept || w_clr_done) begin
            r_busy_cnt <= BUSY_LOAD;
        end else if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - CNT_W'(1);
        end
    end

    // Clear sweep address starts at 0 on entry and walks up while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_addr <= 5'd0;
        end else if (w_is_clear) begin
            r_clr_addr <= 5'd0;
        end else if (w_clr_we) begin
            r_clr_addr <= r_clr_addr + 5'd1;
        end
    end

    // Accepted-byte report and sticky overrun for writes lost while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_valid <= 1'b0;
            r_byte_rs    <= 1'b0;
            r_byte_data  <= 8'h00;
            r_overrun    <= 1'b0;
        end else begin
            r_byte_valid <= w_accept;
            if (w_accept) begin
                r_byte_rs   <= r_rs_s2;
                r_byte_data <= w_byte;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Read-return driver follows the synchronized strobe while rw is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_oe  <= 1'b0;
            r_db_out <= 4'h0;
        end else begin
            r_db_oe  <= r_e_s2 & r_rw_s2;
            r_db_out <= (r_e_s2 & r_rw_s2) ? w_rd_nib : 4'h0;
        end
    end

    // DDRAM write port shared by the clear sweep and data writes.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_ddram[r_clr_addr] <= BLANK_CHAR;
        end else if (w_accept && r_rs_s2) begin
            r_ddram[r_ac] <= w_byte;
        end
    end

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// tb_lcd_nibble_rx: scoreboard bench for lcd_nibble_rx driving whole bus cycles.
module tb_lcd_nibble_rx;

    localparam int BUSY = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic [3:0] lcd_db_in = 4'h0;
    logic [3:0] lcd_db_out;
    logic       lcd_db_oe;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic       busy;
    logic [4:0] ac;
    logic       overrun;
    logic [4:0] dbg_addr = 5'd0;
    logic [7:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_bv = 0;
    int busy_run = 0;
    int busy_len = 0;

    logic [8:0] sb_q[$];
    logic [3:0] rd_q[$];

    lcd_nibble_rx #(.BUSY_CYCLES(BUSY)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_db_in(lcd_db_in), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .busy(busy), .ac(ac), .overrun(overrun), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Accepted bytes are popped from the scoreboard as byte_valid pulses.
    always @(negedge clk) begin
        if (!rst && byte_valid) begin
            n_bv++;
            check_val("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) check_val("byte", {byte_rs, byte_data}, sb_q.pop_front());
        end
    end

    // Length of each busy-high run, in clk cycles.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic rs, input logic rw, input logic [3:0] nib);
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_db_in = nib;
        tick(4);
        lcd_e = 1'b1;
        tick(6);
        if (rw) begin
            check_val("rd_oe", lcd_db_oe, 1);
            check_val("rd_q_nonempty", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) check_val("rd_nib", lcd_db_out, rd_q.pop_front());
        end
        lcd_e = 1'b0;
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] b, input bit accept);
        int lat;
        bus_cycle(rs, 1'b0, b[7:4]);
        tick(6);
        if (accept) sb_q.push_back({rs, b});
        bus_cycle(rs, 1'b0, b[3:0]);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (byte_valid && lat == 0) lat = i;
            if (accept && lat != 0) break;
        end
        check_val(accept ? "wr_latency" : "wr_dropped", lat, accept ? 3 : 0);
        tick(4);
    endtask

    task automatic read_byte(input logic rs, input logic [7:0] exp);
        rd_q.push_back(exp[7:4]);
        rd_q.push_back(exp[3:0]);
        bus_cycle(rs, 1'b1, 4'h0);
        tick(6);
        bus_cycle(rs, 1'b1, 4'h0);
        tick(6);
        check_val("rd_oe_off", lcd_db_oe, 0);
    endtask

    task automatic wait_not_busy(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check_val("busy_timeout", done, 1);
        tick(1);
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check_val(tag, dbg_data, exp);
    endtask

    task automatic outs_zero_check();
        check_val("rst_db_out", lcd_db_out, 0);
        check_val("rst_db_oe", lcd_db_oe, 0);
        check_val("rst_byte_valid", byte_valid, 0);
        check_val("rst_byte_rs", byte_rs, 0);
        check_val("rst_byte_data", byte_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ac", ac, 0);
        check_val("rst_overrun", overrun, 0);
    endtask

    initial begin
        int bv0;
        tick(3);
        outs_zero_check();
        rst = 1'b0;
        tick(3);

        // Set address 5, then data 0x41 at that address.
        write_byte(1'b0, 8'h85, 1'b1);
        check_val("ac_set5", ac, 5);
        check_val("busy_after_wr", busy, 1);
        wait_not_busy(200);
        check_val("busy_len_wr", busy_len, BUSY);
        write_byte(1'b1, 8'h41, 1'b1);
        wait_not_busy(200);
        dbg_check("ddram5_41", 5'd5, 8'h41);
        check_val("ac_6", ac, 6);

        // Clear display.
        write_byte(1'b0, 8'h01, 1'b1);
        wait_not_busy(200);
        check_val("busy_len_clear", busy_len, 32 + BUSY);
        for (int a = 0; a < 32; a++) dbg_check("clear_fill", 5'(a), 8'h20);
        check_val("ac_after_clear", ac, 0);

        // Entry mode decrement, return home, data write wraps ac to 31.
        write_byte(1'b0, 8'h04, 1'b1);
        wait_not_busy(200);
        write_byte(1'b0, 8'h02, 1'b1);
        wait_not_busy(200);
        check_val("ac_home", ac, 0);
        write_byte(1'b1, 8'h55, 1'b1);
        dbg_check("ddram0_55", 5'd0, 8'h55);
        check_val("ac_wrap31", ac, 31);
        wait_not_busy(200);

        // Back-to-back data writes: second one lands while busy.
        bv0 = n_bv;
        check_val("overrun_pre", overrun, 0);
        write_byte(1'b1, 8'h66, 1'b1);
        write_byte(1'b1, 8'h77, 1'b0);
        check_val("overrun_set", overrun, 1);
        dbg_check("ddram31_66", 5'd31, 8'h66);
        dbg_check("ddram30_kept", 5'd30, 8'h20);
        check_val("ac_30", ac, 30);
        check_val("bv_once", n_bv - bv0, 1);
        wait_not_busy(200);

        // A second clear restores increment mode.
        write_byte(1'b0, 8'h01, 1'b1);
        wait_not_busy(200);
        write_byte(1'b1, 8'h33, 1'b1);
        check_val("id_inc_after_clear", ac, 1);
        dbg_check("ddram0_33", 5'd0, 8'h33);
        wait_not_busy(200);

        // Status read while busy with ac=0x12.
        write_byte(1'b0, 8'h92, 1'b1);
        read_byte(1'b0, {1'b1, 2'b00, 5'h12});
        check_val("busy_during_status", busy, 1);
        wait_not_busy(200);

        // Data read at ac=5 holding 0x41, ac advances to 6.
        write_byte(1'b0, 8'h85, 1'b1);
        wait_not_busy(200);
        write_byte(1'b1, 8'h41, 1'b1);
        wait_not_busy(200);
        write_byte(1'b0, 8'h85, 1'b1);
        wait_not_busy(200);
        read_byte(1'b1, 8'h41);
        check_val("ac_after_read", ac, 6);
        check_val("read_no_busy", busy, 0);
        check_val("overrun_sticky", overrun, 1);

        // Reset during a clear sweep aborts it.
        write_byte(1'b0, 8'h01, 1'b1);
        check_val("clear_in_progress", busy, 1);
        rst = 1'b1;
        tick(1);
        check_val("clear_abort_busy", busy, 0);
        rst = 1'b0;
        tick(3);

        // Reset after a lone high nibble discards it.
        bus_cycle(1'b1, 1'b0, 4'hA);
        tick(6);
        rst = 1'b1;
        tick(2);
        outs_zero_check();
        rst = 1'b0;
        tick(2);
        write_byte(1'b1, 8'h42, 1'b1);
        dbg_check("ddram0_42", 5'd0, 8'h42);
        check_val("ac_after_42", ac, 1);
        wait_not_busy(200);

        check_val("sb_drained", sb_q.size(), 0);
        check_val("rd_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
